// File: rtl/ex_sched.sv
`default_nettype none
// ============================================================================
// Module   : ex_sched
// Purpose  : Prioritised exception scheduler.
//            Each cycle at most one event is kept, chosen by fixed priority.
//            It is presented to the host until acknowledged, then one drain
//            cycle follows. Optional macro EX_QUEUE_EN adds a QDEPTH-entry
//            pending queue. Without it, events arriving while busy are dropped
//            and flagged.
// Revision : 1.0  initial release
// ============================================================================
module ex_sched #(
    parameter int QDEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       illegal_op,
    input  logic       cpu_error,
    input  logic       stack_overflow,
    input  logic       i_cache_seg_fault,
    input  logic       d_cache_seg_fault,
    input  logic       alu_op_ex,
    input  logic       breakpoint,
    input  logic [7:0] thr_id,
    input  logic       clr_ex,
    input  logic       clr_ovf,
    output logic [5:0] ex_cause,
    output logic [7:0] cause_thr,
    output logic       csr_stall,
    output logic       ex_valid,
    output logic       ex_overflow,
    output logic [3:0] pend_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPORT = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cause_q, cause_d;
    logic [7:0]  thr_q, thr_d;
    logic        ovf_q, ovf_d;

    logic        ev_any;
    logic [5:0]  ev_code;
    logic        push, pop, drop;
    logic        q_empty, q_full;
    logic [13:0] q_head;

    always_comb begin
        ev_code = 6'h00;
        if (illegal_op || cpu_error)                    ev_code = 6'h05;
        else if (stack_overflow)                        ev_code = 6'h0B;
        else if (i_cache_seg_fault || d_cache_seg_fault) ev_code = 6'h12;
        else if (alu_op_ex)                             ev_code = 6'h01;
        else if (breakpoint)                            ev_code = 6'h3F;
    end

    assign ev_any = (ev_code != 6'h00);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        thr_d   = thr_q;
        push    = 1'b0;
        pop     = 1'b0;
        drop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    // Queued exceptions are older than a fresh event, so they go first.
                    pop     = 1'b1;
                    push    = ev_any;
                    cause_d = q_head[13:8];
                    thr_d   = q_head[7:0];
                    state_d = ST_REPORT;
                end else if (ev_any) begin
                    cause_d = ev_code;
                    thr_d   = thr_id;
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT, ST_DRAIN: begin
                if (ev_any) begin
                    if (q_full) drop = 1'b1;
                    else        push = 1'b1;
                end
                if (state_q == ST_DRAIN) state_d = ST_IDLE;
                else if (clr_ex)         state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cause_q <= 6'h00;
            thr_q   <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            thr_q   <= thr_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef EX_QUEUE_EN
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [13:0]   mem_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    cnt_q, cnt_d;

    assign q_empty = (cnt_q == 4'd0);
    assign q_full  = (cnt_q == 4'(QDEPTH));
    assign q_head  = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 4'd1;
        else if (pop && !push) cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {ev_code, thr_id};
    end

    assign pend_cnt = cnt_q;
`else
    logic unused_q;

    assign q_empty  = 1'b1;
    assign q_full   = 1'b1;
    assign q_head   = 14'h0000;
    assign pend_cnt = 4'd0;
    assign unused_q = push | pop | (QDEPTH != 0);
`endif

    assign ex_valid    = (state_q == ST_REPORT);
    assign csr_stall   = ex_valid;
    assign ex_cause    = ex_valid ? cause_q : 6'h00;
    assign cause_thr   = ex_valid ? thr_q   : 8'h00;
    assign ex_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_sched
// Purpose  : Randomised bench for ex_sched against a queue-based reference
//            model, plus directed literal checks of the key scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_sched;

    localparam int QD = 4;
`ifdef EX_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clk, rst_n;
    logic       illegal_op, cpu_error, stack_overflow;
    logic       i_cache_seg_fault, d_cache_seg_fault, alu_op_ex, breakpoint;
    logic [7:0] thr_id;
    logic       clr_ex, clr_ovf;
    logic [5:0] ex_cause;
    logic [7:0] cause_thr;
    logic       csr_stall, ex_valid, ex_overflow;
    logic [3:0] pend_cnt;

    int vectors    = 0;
    int miscompares = 0;

    ex_sched #(.QDEPTH(QD)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .illegal_op        (illegal_op),
        .cpu_error         (cpu_error),
        .stack_overflow    (stack_overflow),
        .i_cache_seg_fault (i_cache_seg_fault),
        .d_cache_seg_fault (d_cache_seg_fault),
        .alu_op_ex         (alu_op_ex),
        .breakpoint        (breakpoint),
        .thr_id            (thr_id),
        .clr_ex            (clr_ex),
        .clr_ovf           (clr_ovf),
        .ex_cause          (ex_cause),
        .cause_thr         (cause_thr),
        .csr_stall         (csr_stall),
        .ex_valid          (ex_valid),
        .ex_overflow       (ex_overflow),
        .pend_cnt          (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event mask bit order: {illegal, cpu_err, stack, iseg, dseg, alu, bp}
    localparam logic [6:0] E_BP  = 7'b0000001;
    localparam logic [6:0] E_ALU = 7'b0000010;
    localparam logic [6:0] E_DSG = 7'b0000100;
    localparam logic [6:0] E_STK = 7'b0010000;
    localparam logic [6:0] E_ILL = 7'b1000000;

    function automatic logic [5:0] code_of(input logic [6:0] ev);
        if (ev[6] | ev[5])      return 6'h05;
        else if (ev[4])         return 6'h0B;
        else if (ev[3] | ev[2]) return 6'h12;
        else if (ev[1])         return 6'h01;
        else if (ev[0])         return 6'h3F;
        return 6'h00;
    endfunction

    // ---------------- reference model ----------------
    int          m_st   = 0;     // 0 idle, 1 presenting, 2 drain
    logic [5:0]  m_code = 6'h00;
    logic [7:0]  m_thr  = 8'h00;
    bit          m_ovf  = 1'b0;
    logic [13:0] m_q[$];
    logic [13:0] m_e;
    logic [5:0]  m_c;
    bit          m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_code = 6'h00; m_thr = 8'h00; m_ovf = 1'b0;
            m_q.delete();
        end else begin
            m_c    = code_of({illegal_op, cpu_error, stack_overflow, i_cache_seg_fault,
                              d_cache_seg_fault, alu_op_ex, breakpoint});
            m_drop = 1'b0;
            if (m_st == 0) begin
                if (m_q.size() > 0) begin
                    m_e = m_q.pop_front();
                    m_code = m_e[13:8]; m_thr = m_e[7:0];
                    if (m_c != 0) m_q.push_back({m_c, thr_id});
                    m_st = 1;
                end else if (m_c != 0) begin
                    m_code = m_c; m_thr = thr_id; m_st = 1;
                end
            end else begin
                if (m_c != 0) begin
                    if (QEN && m_q.size() < QD) m_q.push_back({m_c, thr_id});
                    else                        m_drop = 1'b1;
                end
                if (m_st == 2)   m_st = 0;
                else if (clr_ex) m_st = 2;
            end
            if (m_drop)       m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [27:0] exp_v, act_v;
    always @(negedge clk) begin
        exp_v = {(m_st == 1), (m_st == 1), (m_st == 1) ? m_code : 6'h00,
                 (m_st == 1) ? m_thr : 8'h00, m_ovf, 4'(m_q.size()), 2'b00};
        act_v = {ex_valid, csr_stall, ex_cause, cause_thr, ex_overflow, pend_cnt, 2'b00};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL model t=%0t got valid=%b stall=%b cause=%h thr=%h ovf=%b pend=%0d want valid=%b stall=%b cause=%h thr=%h ovf=%b pend=%0d",
                     $time, act_v[27], act_v[26], act_v[25:20], act_v[19:12], act_v[11], act_v[10:7],
                     exp_v[27], exp_v[26], exp_v[25:20], exp_v[19:12], exp_v[11], exp_v[10:7]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, 32'(ex_valid), 32'd0);
        chk({name, "_stall"}, 32'(csr_stall), 32'd0);
        chk({name, "_cause"}, 32'(ex_cause), 32'd0);
        chk({name, "_thr"},   32'(cause_thr), 32'd0);
    endtask

    task automatic cyc(input logic [6:0] ev, input logic [7:0] thr, input logic cx, input logic co);
        {illegal_op, cpu_error, stack_overflow, i_cache_seg_fault,
         d_cache_seg_fault, alu_op_ex, breakpoint} = ev;
        thr_id  = thr;
        clr_ex  = cx;
        clr_ovf = co;
        @(posedge clk); #1;
    endtask

    logic [6:0] r_ev;

    initial begin
        rst_n = 1'b1;
        {illegal_op, cpu_error, stack_overflow, i_cache_seg_fault,
         d_cache_seg_fault, alu_op_ex, breakpoint} = 7'd0;
        thr_id = 8'h00; clr_ex = 1'b0; clr_ovf = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        chk("reset_ovf",  32'(ex_overflow), 32'd0);
        chk("reset_pend", 32'(pend_cnt), 32'd0);
        rst_n = 1'b1;
        cyc(7'd0, 8'h00, 1'b0, 1'b0);

        // Single breakpoint from idle: presented the next cycle
        cyc(E_BP, 8'h07, 1'b0, 1'b0);
        chk("bp_valid", 32'(ex_valid), 32'd1);
        chk("bp_stall", 32'(csr_stall), 32'd1);
        chk("bp_cause", 32'(ex_cause), 32'h3F);
        chk("bp_thr",   32'(cause_thr), 32'h07);
        cyc(7'd0, 8'h00, 1'b1, 1'b0);
        chk_zero("drain");
        cyc(7'd0, 8'h00, 1'b0, 1'b0);

        // Coincident events: highest priority wins, losers silently discarded
        cyc(E_ILL | E_STK | E_BP, 8'h02, 1'b0, 1'b0);
        chk("prio_cause", 32'(ex_cause), 32'h05);
        chk("prio_thr",   32'(cause_thr), 32'h02);
        chk("prio_pend",  32'(pend_cnt), 32'd0);
        chk("prio_ovf",   32'(ex_overflow), 32'd0);

`ifdef EX_QUEUE_EN
        for (int i = 0; i < 4; i++) cyc(E_ALU, 8'h10 + 8'(i), 1'b0, 1'b0);
        chk("q_pend4", 32'(pend_cnt), 32'd4);
        chk("q_ovf0",  32'(ex_overflow), 32'd0);
        cyc(E_BP, 8'h14, 1'b0, 1'b0);
        chk("q_ovf1",  32'(ex_overflow), 32'd1);
        chk("q_pend_full", 32'(pend_cnt), 32'd4);
        cyc(7'd0, 8'h00, 1'b1, 1'b0);
        chk_zero("q_drain");
        cyc(7'd0, 8'h00, 1'b0, 1'b0);
        cyc(7'd0, 8'h00, 1'b0, 1'b0);
        chk("q_pop_thr",   32'(cause_thr), 32'h10);
        chk("q_pop_cause", 32'(ex_cause), 32'h01);
        chk("q_pend3",     32'(pend_cnt), 32'd3);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        chk("mid_rst_pend", 32'(pend_cnt), 32'd0);
        chk("mid_rst_ovf",  32'(ex_overflow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(7'd0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_pend", 32'(pend_cnt), 32'd0);
        cyc(E_BP, 8'h30, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        cyc(E_DSG, 8'h20, 1'b1, 1'b0);
        chk("clr_push_valid", 32'(ex_valid), 32'd0);
        chk("clr_push_pend",  32'(pend_cnt), 32'd1);
        cyc(7'd0, 8'h00, 1'b0, 1'b0);
        cyc(7'd0, 8'h00, 1'b0, 1'b0);
        chk("seg_cause", 32'(ex_cause), 32'h12);
        chk("seg_thr",   32'(cause_thr), 32'h20);
        cyc(7'd0, 8'h00, 1'b1, 1'b0);
        cyc(7'd0, 8'h00, 1'b0, 1'b0);
`else
        cyc(E_ALU, 8'h33, 1'b0, 1'b0);
        chk("nq_ovf1",  32'(ex_overflow), 32'd1);
        chk("nq_pend",  32'(pend_cnt), 32'd0);
        chk("nq_keep",  32'(ex_cause), 32'h05);
        cyc(7'd0, 8'h00, 1'b0, 1'b1);
        chk("nq_ovf0",  32'(ex_overflow), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        chk("mid_rst_pend", 32'(pend_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(7'd0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_valid0", 32'(ex_valid), 32'd0);
        cyc(E_BP, 8'h44, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_thr",   32'(cause_thr), 32'h44);
        cyc(7'd0, 8'h00, 1'b1, 1'b0);
        cyc(7'd0, 8'h00, 1'b0, 1'b0);
`endif

        // Randomised traffic, checked every cycle by the model compare
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                cyc(7'd0, 8'h00, 1'b0, 1'b0);
                rst_n = 1'b1;
            end
            r_ev = ($urandom_range(0, 99) < 45) ? 7'($urandom) : 7'd0;
            cyc(r_ev, 8'($urandom), ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10));
        end
        cyc(7'd0, 8'h00, 1'b0, 1'b0);
        cyc(7'd0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_sched.md
EX_SCHED -- requirements
Module: ex_sched

Interface
REQ-001 Parameter: QDEPTH, default 4, pending-exception queue depth (power of two, 2..8); meaningful only with EX_QUEUE_EN.
REQ-002 clk  input  1  global clock; all state updates on rising edge.
REQ-003 rst_n  input  1  global reset, asynchronous, active-low.
REQ-004 illegal_op  input  1  illegal-opcode event.
REQ-005 cpu_error  input  1  unrecoverable error event; treated as illegal_op.
REQ-006 stack_overflow  input  1  stack-overflow event.
REQ-007 i_cache_seg_fault  input  1  instruction-side segfault event.
REQ-008 d_cache_seg_fault  input  1  data-side segfault event.
REQ-009 alu_op_ex  input  1  ALU exception event.
REQ-010 breakpoint  input  1  user breakpoint event.
REQ-011 thr_id  input  8  faulting thread id, sampled with the event.
REQ-012 clr_ex  input  1  host acknowledge of the presented exception (one-cycle pulse).
REQ-013 clr_ovf  input  1  clears the sticky overflow flag.
REQ-014 ex_cause  output  6  presented exception code, 0x00 when none.
REQ-015 cause_thr  output  8  thread id of presented exception, 0x00 when none.
REQ-016 csr_stall  output  1  pipeline stall while an exception is presented.
REQ-017 ex_valid  output  1  ex_cause/cause_thr hold a valid exception.
REQ-018 ex_overflow  output  1  sticky: an exception was dropped.
REQ-019 pend_cnt  output  4  number of queued (not presented) exceptions.

Function
REQ-020 Per cycle, OR of event inputs forms at most one event; code by fixed priority: illegal_op|cpu_error 0x05 > stack_overflow 0x0B > either seg_fault 0x12 > alu_op_ex 0x01 > breakpoint 0x3F.
REQ-021 Lower-priority events coincident with a higher one are discarded without setting ex_overflow.
REQ-022 FSM states IDLE, REPORT, DRAIN; reset to IDLE.
REQ-023 IDLE: if queue non-empty, pop head into present register and go REPORT; else if event, load event directly and go REPORT; else stay.
REQ-024 IDLE with non-empty queue and new event in the same cycle: pop head and push new event in that cycle (simultaneous push/pop; pend_cnt unchanged).
REQ-025 REPORT: ex_valid=1, csr_stall=1, outputs show present register; stays until clr_ex=1, then go DRAIN.
REQ-026 DRAIN: one cycle, ex_valid=0, csr_stall=0, ex_cause=0x00, cause_thr=0x00; then IDLE.
REQ-027 Latency: event at cycle N with FSM IDLE and queue empty -> ex_valid/csr_stall high at N+1.
REQ-028 Events in REPORT or DRAIN (including same cycle as clr_ex) are pushed to the queue in arrival order.
REQ-029 Queue full and push requested (no simultaneous pop) -> event dropped, ex_overflow set next cycle, queue unchanged.
REQ-030 ex_overflow clears only on clr_ovf or reset; set has priority over simultaneous clr_ovf.
REQ-031 clr_ex in IDLE or DRAIN is ignored.
REQ-032 Queue pointers wrap modulo QDEPTH; pend_cnt ranges 0..QDEPTH.

Reset
REQ-033 rst_n low asynchronously forces: state IDLE, queue empty, pend_cnt 0, ex_valid 0, csr_stall 0, ex_cause 0x00, cause_thr 0x00, ex_overflow 0.
REQ-034 Reset mid-REPORT discards presented and queued exceptions; first event after release follows REQ-027.

Configuration
REQ-035 Macro EX_QUEUE_EN defined: queue of QDEPTH entries per REQ-023..REQ-032.
REQ-036 EX_QUEUE_EN undefined: no queue; any event outside IDLE is dropped and sets ex_overflow; pend_cnt tied to 0.

Verification
REQ-037 Idle, pulse breakpoint with thr_id=0x07 -> next cycle ex_valid=1, csr_stall=1, ex_cause=0x3F, cause_thr=0x07.
REQ-038 Same cycle illegal_op+stack_overflow+breakpoint, thr_id=0x02 -> ex_cause=0x05, pend_cnt=0, ex_overflow=0.
REQ-039 (EX_QUEUE_EN) In REPORT, push events with thr 0x10,0x11,0x12,0x13 -> pend_cnt=4; fifth -> ex_overflow=1; clr_ex -> DRAIN one cycle with outputs zero, then presents thr 0x10.
REQ-040 (EX_QUEUE_EN) clr_ex and d_cache_seg_fault (thr 0x20) same cycle in REPORT -> DRAIN, then REPORT with ex_cause=0x12, cause_thr=0x20.
REQ-041 Assert rst_n low mid-REPORT with pend_cnt=3 -> all outputs zero immediately, pend_cnt=0 after release.
REQ-042 (no EX_QUEUE_EN) alu_op_ex during REPORT -> dropped, ex_overflow=1; clr_ovf -> ex_overflow=0 next cycle.
